// File: rtl/aes_key_expander_pkg.sv
// aes_key_expander_pkg: shared AES-128 key-schedule constants, FSM states and GF(2^8) helpers.
package aes_key_expander_pkg;
    localparam int NR = 10;
    localparam int KEY_W = 128;
    localparam int IDX_W = 4;
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t LAST = idx_t'(NR);
    localparam logic [7:0] RCON0 = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction
endpackage

// File: rtl/aes_key_expander_if.sv
// aes_key_expander_if: load / round-select / round-key bundle between the cipher controllers and the key store.
interface aes_key_expander_if;
    import aes_key_expander_pkg::*;
    logic key_load;
    logic [KEY_W-1:0] key_in;
    idx_t sel_key;
    logic [KEY_W-1:0] round_key;
    logic key_ready;
    logic busy;

    modport master (output key_load, key_in, sel_key, input round_key, key_ready, busy);
    modport slave (input key_load, key_in, sel_key, output round_key, key_ready, busy);
endinterface

// File: rtl/aes_key_expander_sbox.sv
// aes_key_expander_sbox: combinational AES S-box (GF(2^8) multiplicative inverse followed by the affine map).
module aes_key_expander_sbox
    import aes_key_expander_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] sub
);
    logic [7:0] sq;
    logic [7:0] inv;

    always_comb begin
        sq = value;
        inv = 8'h01;
        // x^254 = x^2 * x^4 * ... * x^128, which also maps 0 to 0 as the S-box needs
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        sub = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// File: rtl/aes_key_expander.sv
// aes_key_expander: AES-128 key schedule producing one round key per clock into an 11-entry store,
// read by round index so the encrypt (0->10) and decrypt (10->0) controllers share it.
module aes_key_expander
    import aes_key_expander_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    aes_key_expander_if.slave bus
);
    state_t state, state_n;
    idx_t round_cnt, cnt_n, wr_idx;
    logic [7:0] rcon, rcon_n;
    logic [KEY_W-1:0] keys [0:NR];
    logic [KEY_W-1:0] prev_key, next_key, wr_data, round_key;
    logic wr_en;
    logic [31:0] rot_word, sub_word, t_word, n0, n1, n2, n3;

    assign prev_key = keys[round_cnt == '0 ? idx_t'(0) : round_cnt - idx_t'(1)];
    assign rot_word = {prev_key[23:0], prev_key[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_key_expander_sbox u_sbox (.value(rot_word[8*i +: 8]), .sub(sub_word[8*i +: 8]));
    end

    assign t_word = sub_word ^ {rcon, 24'h0};
    assign n0 = prev_key[127:96] ^ t_word;
    assign n1 = prev_key[95:64] ^ n0;
    assign n2 = prev_key[63:32] ^ n1;
    assign n3 = prev_key[31:0] ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // A load restarts the schedule from any state, abandoning a running expansion
    always_comb begin
        state_n = state;
        cnt_n = round_cnt;
        rcon_n = rcon;
        wr_en = 1'b0;
        wr_idx = '0;
        wr_data = next_key;
        if (bus.key_load) begin
            state_n = EXPAND;
            cnt_n = idx_t'(1);
            rcon_n = RCON0;
            wr_en = 1'b1;
            wr_data = bus.key_in;
        end else if (state == EXPAND) begin
            wr_en = 1'b1;
            wr_idx = round_cnt;
            rcon_n = xtime(rcon);
            state_n = round_cnt == LAST ? READY : EXPAND;
            cnt_n = round_cnt == LAST ? round_cnt : round_cnt + idx_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_cnt <= '0;
            rcon <= RCON0;
            round_key <= '0;
            for (int k = 0; k <= NR; k++) keys[k] <= '0;
        end else begin
            round_cnt <= cnt_n;
            rcon <= rcon_n;
            if (wr_en) keys[wr_idx] <= wr_data;
            round_key <= (bus.sel_key <= LAST) ? keys[bus.sel_key] : '0;
        end
    end

    assign bus.round_key = round_key;
    assign bus.key_ready = state == READY;
    assign bus.busy = state == EXPAND;
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: random and FIPS-197 stimulus against a word-level key-schedule model, scoreboard-checked.
module tb_aes_key_expander;
    typedef struct packed {
        logic [127:0] key;
        logic ready;
        logic busy;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rd_req = 1'b0;
    logic pending;
    int n_cmp = 0;
    int n_bad = 0;

    item_t sb[$];
    string names[$];

    logic [7:0] sbox [0:255];
    logic [7:0] rc [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] sched [0:10];
    logic [127:0] stored [0:10];
    int edge_n = 0;
    int last_ld = 0;
    bit have = 0;

    localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_expander_if bus();

    aes_key_expander dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] rkey();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    // FIPS-197 word recurrence: w[i] = w[i-4] ^ (SubWord(RotWord(w[i-1])) ^ Rcon) every fourth word
    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0)
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc[i/4], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic cycle(input logic ld, input logic [127:0] k, input logic [3:0] s, input logic rd,
                         input logic use_c, input logic [127:0] cval, input string nm);
        logic [127:0] e;
        int d;
        item_t it;
        bus.key_load = ld;
        bus.key_in = k;
        bus.sel_key = s;
        rd_req = rd;
        e = (s <= 4'd10) ? stored[s] : '0;
        if (use_c) e = cval;
        if (ld) begin
            last_ld = edge_n;
            have = 1;
            expand(k);
        end
        d = edge_n - last_ld;
        if (have && d <= 10) stored[d] = sched[d];
        if (rd) begin
            it.key = e;
            it.ready = have && d >= 10;
            it.busy = have && d < 10;
            sb.push_back(it);
            names.push_back(nm);
        end
        edge_n++;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge rst_n)
        if (!rst_n) pending <= 1'b0;
        else pending <= rd_req;

    always @(negedge clk) begin
        if (pending) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: got read with no expectation, want queued item");
            end else begin
                item_t it;
                string nm;
                it = sb.pop_front();
                nm = names.pop_front();
                if (bus.round_key !== it.key || bus.key_ready !== it.ready || bus.busy !== it.busy) begin
                    n_bad++;
                    $display("FAIL %s: got key=%h ready=%b busy=%b want key=%h ready=%b busy=%b",
                             nm, bus.round_key, bus.key_ready, bus.busy, it.key, it.ready, it.busy);
                end
            end
        end
    end

    initial begin
        logic [127:0] k;
        bus.key_load = 1'b0;
        bus.key_in = '0;
        bus.sel_key = '0;
        for (int i = 0; i <= 10; i++) stored[i] = '0;
        build_sbox();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.key_load = 1'($urandom);
            bus.key_in = rkey();
            bus.sel_key = 4'($urandom);
            @(posedge clk);
            #1;
            chk("reset_round_key", bus.round_key, '0);
            chk("reset_key_ready", 128'(bus.key_ready), '0);
            chk("reset_busy", 128'(bus.busy), '0);
        end
        bus.key_load = 1'b0;
        rst_n = 1'b1;
        cycle(0, '0, 4'd0, 1, 0, '0, "idle_read");

        cycle(1, A1_KEY, 4'd1, 1, 0, '0, "a1_load");
        for (int i = 0; i < 10; i++) cycle(0, '0, 4'd1, 1, 0, '0, "a1_expand");
        cycle(0, '0, 4'd1, 1, 1, A1_R1, "a1_round1");
        cycle(0, '0, 4'd10, 1, 1, A1_R10, "a1_round10");
        cycle(0, '0, 4'd0, 1, 1, A1_KEY, "a1_round0");
        for (int s = 10; s >= 0; s--) cycle(0, '0, 4'(s), 1, 0, '0, "decrypt_sweep");

        cycle(1, A1_KEY, 4'd10, 1, 0, '0, "restart_first");
        for (int i = 0; i < 4; i++) cycle(0, '0, 4'd10, 1, 0, '0, "restart_mid");
        cycle(1, '0, 4'd10, 1, 0, '0, "restart_second");
        for (int i = 0; i < 10; i++) cycle(0, '0, 4'd10, 1, 0, '0, "restart_expand");
        cycle(0, '0, 4'd10, 1, 1, ZERO_R10, "zero_round10");

        k = rkey();
        cycle(1, k, 4'd0, 1, 0, '0, "abort_load");
        for (int i = 0; i < 3; i++) cycle(0, '0, 4'd0, 1, 0, '0, "abort_expand");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        have = 0;
        for (int i = 0; i <= 10; i++) stored[i] = '0;
        #1;
        chk("abort_round_key", bus.round_key, '0);
        chk("abort_key_ready", 128'(bus.key_ready), '0);
        chk("abort_busy", 128'(bus.busy), '0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int s = 0; s <= 10; s++) cycle(0, '0, 4'(s), 1, 0, '0, "post_abort_zero");

        cycle(1, rkey(), 4'd0, 1, 0, '0, "range_load");
        for (int i = 0; i < 10; i++) cycle(0, '0, 4'd5, 1, 0, '0, "range_expand");
        cycle(0, '0, 4'd11, 1, 1, '0, "sel_11");
        cycle(0, '0, 4'd15, 1, 1, '0, "sel_15");

        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 14) == 0, rkey(), 4'($urandom_range(0, 15)), 1, 0, '0, "random");

        for (int i = 0; i < 3; i++) cycle(0, '0, 4'd0, 0, 0, '0, "drain");
        @(negedge clk);
        #1;
        chk("sb_drain", 128'(sb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
